// File: rtl/bp_pkg.sv
// Shared geometry, pipeline metadata and BTB entry layout for the fetch-stage branch predictor.
// Geometry lives here so the meta/entry structs and every user of them stay width-consistent.
package bp_pkg;

    localparam int BP_XLEN    = 32;
    localparam int BP_ENTRIES = 64;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = 8;
    localparam int BP_CTR_W   = 2;
    localparam int BP_GHR_W   = 6;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic [BP_GHR_W-1:0] ghr;
    } bp_meta_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
    } btb_entry_t;

    // Saturating up/down step of a direction counter.
    function automatic logic [BP_CTR_W-1:0] sat_inc_dec(input logic [BP_CTR_W-1:0] ctr,
                                                         input logic              inc);
        logic [BP_CTR_W-1:0] res;
        res = ctr;
        if (inc && (ctr != '1)) begin
            res = ctr + 1'b1;
        end else if (!inc && (ctr != '0)) begin
            res = ctr - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_btb_array.sv
// Tagged BTB storage: one combinational read port, one posedge write port.
// Only the valid bits are reset; tag/target payload is don't-care while invalid.
module bp_btb_array
    import bp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BP_IDX_W-1:0] i_rd_idx,
    output btb_entry_t          o_rd_entry,
    input  logic                i_wr_en,
    input  logic [BP_IDX_W-1:0] i_wr_idx,
    input  btb_entry_t          i_wr_entry
);

    logic [BP_ENTRIES-1:0] r_valid;
    logic [BP_TAG_W-1:0]   r_tag    [BP_ENTRIES];
    logic [BP_XLEN-1:0]    r_target [BP_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_entry.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]    <= i_wr_entry.tag;
            r_target[i_wr_idx] <= i_wr_entry.target;
        end
    end

    // Read sees pre-write contents when the same entry is written this cycle.
    assign o_rd_entry = '{valid:  r_valid[i_rd_idx],
                          tag:    r_tag[i_rd_idx],
                          target: r_target[i_rd_idx]};

endmodule

// File: rtl/bp_gshare_btb.sv
// Fetch-stage predictor: saturating-counter direction table (bimodal or gshare) plus tagged BTB,
// speculative GHR with mispredict repair, and saturating branch/mispredict counters.
module bp_gshare_btb
    import bp_pkg::*;
#(
    parameter bit GSHARE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid_i,
    input  logic [BP_XLEN-1:0] fetch_pc_i,
    output logic               pred_taken_o,
    output logic [BP_XLEN-1:0] pred_target_o,
    output bp_meta_t           pred_meta_o,
    input  logic               upd_valid_i,
    input  logic [BP_XLEN-1:0] upd_pc_i,
    input  logic               upd_taken_i,
    input  logic [BP_XLEN-1:0] upd_target_i,
    input  logic               upd_mispred_i,
    input  bp_meta_t           upd_meta_i,
    output logic [31:0]        perf_br_o,
    output logic [31:0]        perf_misp_o
);

    localparam logic [BP_CTR_W-1:0] CTR_INIT = BP_CTR_W'((1 << (BP_CTR_W - 1)) - 1);

    logic [BP_CTR_W-1:0] r_ctr [BP_ENTRIES];
    logic [BP_GHR_W-1:0] r_ghr;
    logic [31:0]         r_perf_br;
    logic [31:0]         r_perf_misp;

    logic [BP_IDX_W-1:0] w_fetch_idx;
    logic [BP_IDX_W-1:0] w_ctr_idx;
    logic [BP_IDX_W-1:0] w_upd_idx;
    logic [BP_TAG_W-1:0] w_fetch_tag;
    btb_entry_t          w_rd_entry;
    btb_entry_t          w_wr_entry;
    logic                w_hit;
    logic                w_taken;
    logic                w_upd;
    logic                w_unused;

    assign w_fetch_idx = fetch_pc_i[BP_IDX_W+1:2];
    assign w_fetch_tag = fetch_pc_i[BP_IDX_W+2 +: BP_TAG_W];
    assign w_upd_idx   = upd_pc_i[BP_IDX_W+1:2];
    assign w_ctr_idx   = GSHARE ? (w_fetch_idx ^ BP_IDX_W'(r_ghr)) : w_fetch_idx;
    assign w_upd       = upd_valid_i & ~rst;

    assign w_wr_entry = '{valid:  1'b1,
                          tag:    upd_pc_i[BP_IDX_W+2 +: BP_TAG_W],
                          target: upd_target_i};

    // Not-taken branches never allocate, so only taken resolutions write the BTB.
    bp_btb_array u_btb (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_fetch_idx),
        .o_rd_entry (w_rd_entry),
        .i_wr_en    (w_upd & upd_taken_i),
        .i_wr_idx   (w_upd_idx),
        .i_wr_entry (w_wr_entry)
    );

    assign w_hit   = w_rd_entry.valid && (w_rd_entry.tag == w_fetch_tag);
    assign w_taken = w_hit && r_ctr[w_ctr_idx][BP_CTR_W-1];

    assign pred_taken_o  = w_taken;
    assign pred_target_o = w_taken ? w_rd_entry.target : (fetch_pc_i + BP_XLEN'(4));
    assign pred_meta_o   = '{idx: w_ctr_idx, ghr: r_ghr};
    assign perf_br_o     = r_perf_br;
    assign perf_misp_o   = r_perf_misp;

    // The update index comes back verbatim from prediction time; never recomputed here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (w_upd) begin
            r_ctr[upd_meta_i.idx] <= sat_inc_dec(r_ctr[upd_meta_i.idx], upd_taken_i);
        end
    end

    // Repair from the snapshot outranks the speculative shift in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_upd && upd_mispred_i) begin
            r_ghr <= {upd_meta_i.ghr[BP_GHR_W-2:0], upd_taken_i};
        end else if (fetch_valid_i && w_hit) begin
            r_ghr <= {r_ghr[BP_GHR_W-2:0], w_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_br   <= '0;
            r_perf_misp <= '0;
        end else if (w_upd) begin
            if (r_perf_br != '1) begin
                r_perf_br <= r_perf_br + 32'd1;
            end
            if (upd_mispred_i && (r_perf_misp != '1)) begin
                r_perf_misp <= r_perf_misp + 32'd1;
            end
        end
    end

    // PC bits outside the index/tag fields do not participate in prediction.
    assign w_unused = ^{fetch_pc_i[BP_XLEN-1:BP_IDX_W+2+BP_TAG_W], fetch_pc_i[1:0],
                        upd_pc_i[BP_XLEN-1:BP_IDX_W+2+BP_TAG_W], upd_pc_i[1:0]};

endmodule
